st_latency_adapter: RTL and testbench
=====================================

# st_latency_adapter

Parametrised Avalon-ST ready-latency adapter for the image-processor streaming fabric. It sits between a source with ready latency IN_RL and a sink with ready latency OUT_RL. Any pair of latencies from 0 to 4 is supported, with no data loss and no protocol violations. An internal synchronous FIFO absorbs in-flight beats. The block also reports occupancy, overflow and upstream protocol-violation status.

## Interface
- DATA_W, 32: data bits per beat.
- EMPTY_W, 2: width of empty field.
- IN_RL, 1: ready latency of the upstream interface, range 0..4.
- OUT_RL, 0: ready latency of the downstream interface, range 0..4.
- DEPTH, 4: FIFO depth in beats. Must be ≥ IN_RL+1; elaboration error otherwise.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_ready  out  1  upstream permission.
- in_valid  in  1  upstream beat valid.
- in_data  in  DATA_W  beat data.
- in_startofpacket, in_endofpacket  in  1 each  packet delimiters.
- in_empty  in  EMPTY_W  empty symbols.
- out_ready  in  1  downstream permission.
- out_valid  out  1  downstream beat valid.
- out_data, out_startofpacket, out_endofpacket, out_empty  out  DATA_W/1/1/EMPTY_W  beat payload.
- occupancy  out  $clog2(DEPTH+1)  beats currently stored.
- overflow_err  out  1  sticky; a beat arrived while the FIFO was full.
- protocol_err  out  1  sticky; a beat arrived without a matching in_ready.

## Operation
- Payload: {data, sop, eop, empty}, width DATA_W+EMPTY_W+2. Stored unmodified, in order.
- in_ready is combinational from registered occupancy: in_ready = (occupancy + IN_RL < DEPTH).
- This guarantees space for every beat granted in the last IN_RL+1 cycles. Pops only add margin.
- Input accept:
  - IN_RL=0: push when in_valid && in_ready.
  - IN_RL>0: push when in_valid.
- Upstream permission history:
  - rdy_hist is a shift register of in_ready, IN_RL stages.
  - For IN_RL>0, a beat is legal only if rdy_hist[IN_RL-1] is 1.
  - Illegal beat: set protocol_err. The beat is still pushed if space exists.
- Overflow: a push while occupancy==DEPTH is dropped, sets overflow_err, and leaves the FIFO unchanged.
- Output side:
  - orh is a shift register of out_ready, OUT_RL stages.
  - OUT_RL=0: out_valid = (occupancy≠0); pop = out_valid && out_ready.
  - OUT_RL>0: out_valid = (occupancy≠0) && orh[OUT_RL-1]; pop = out_valid.
- Simultaneous push and pop: occupancy unchanged. When occupancy==1, the pushed beat lands behind the popped one.
- occupancy never wraps. Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Output payload is driven from the FIFO head.
  - While out_valid=0, the payload holds the last head value (don't-care for checks).

## Timing
- Reset values:
  - in_ready = (IN_RL < DEPTH), i.e. 1.
  - out_valid 0; out payload 0; occupancy 0; overflow_err 0; protocol_err 0.
  - rdy_hist 0; orh 0; FIFO pointers 0.
- Asynchronous reset mid-stream discards all stored and in-flight beats. Sticky flags clear only on reset.
- Minimum latency: 1 cycle from an accepted input beat to out_valid, when OUT_RL=0 or orh[OUT_RL-1]=1.
- Full throughput (one beat per cycle, sustained) requires DEPTH ≥ IN_RL+OUT_RL+2. Smaller DEPTH is legal with bubbles.
- in_ready has a combinational path from registered state only. out_valid for OUT_RL>0 has no path from out_ready.
- For OUT_RL=0, out_valid never depends on out_ready.

## Structure
- Package st_adapter_pkg holds:
  - the payload struct builder: function payload width = DATA_W+EMPTY_W+2;
  - localparam MAX_RL = 4;
  - the depth-check assertion macro.
- Sub-module st_sc_fifo: single-clock FIFO with registered count and non-power-of-two wrap.
  - Ports: push, pop, wdata, rdata, count, full, empty.
- The top level holds the two latency history shifters, the credit check and the error flags.

## Test plan
- IN_RL=1, OUT_RL=0, DEPTH=4, out_ready=1, 20 back-to-back beats 0..19 -> all 20 delivered in order, 1-cycle latency, occupancy ≤1, no errors.
- IN_RL=4, OUT_RL=0, DEPTH=5, out_ready held 0, upstream sends on every permitted cycle:
  - in_ready deasserts when occupancy+4 ≥ 5;
  - exactly 5 beats stored, overflow_err stays 0.
- IN_RL=0, OUT_RL=2, DEPTH=4, out_ready toggling 1,0,1,0:
  - out_valid asserted only 2 cycles after each out_ready=1;
  - data order preserved.
- IN_RL=2: inject in_valid with rdy_hist[1]=0 -> protocol_err=1 next cycle and stays 1. Force a push at full -> overflow_err=1, occupancy stays DEPTH.
- DEPTH=3 (non-power-of-two), 10 beats with random out_ready -> pointer wrap correct, payload incl. sop/eop/empty intact.
- Assert reset_n low mid-packet with occupancy=3 -> all outputs at reset values immediately. After release, a new packet flows cleanly.

Source files
------------

// File: rtl/st_latency_adapter_pkg.sv
// Shared definitions for the Avalon-ST ready-latency adapter: payload sizing,
// latency limits and the elaboration-time parameter guard.
`ifndef ST_ADAPTER_PKG_SV
`define ST_ADAPTER_PKG_SV

// The FIFO must hold every beat granted during the IN_RL+1 cycles before in_ready drops.
`define ST_ADAPTER_DEPTH_CHECK(depth, in_rl, out_rl) \
  if ((depth) < (in_rl) + 1 || (in_rl) < 0 || (out_rl) < 0 || \
      (in_rl) > st_adapter_pkg::MAX_RL || (out_rl) > st_adapter_pkg::MAX_RL) begin : g_param_check \
    $error("st_latency_adapter: DEPTH must be >= IN_RL+1 and ready latencies must be 0..4"); \
  end

package st_adapter_pkg;

  localparam int MAX_RL = 4;

  function automatic int payload_width(input int data_w, input int empty_w);
    return data_w + empty_w + 2;
  endfunction

endpackage

`endif

// File: rtl/st_sc_fifo.sv
// Single-clock FIFO with a registered count; pointers wrap at DEPTH so any depth works.
module st_sc_fifo
  import st_adapter_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // A push into a full FIFO is dropped; the caller flags it.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/st_latency_adapter.sv
// Avalon-ST ready-latency adapter: bridges an IN_RL source to an OUT_RL sink through a
// small FIFO and reports occupancy plus sticky overflow / upstream protocol errors.
module st_latency_adapter
  import st_adapter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int IN_RL   = 1,
  parameter int OUT_RL  = 0,
  parameter int DEPTH   = 4,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [OCC_W-1:0]   occupancy,
  output logic               overflow_err,
  output logic               protocol_err
);

  localparam int PAY_W = payload_width(DATA_W, EMPTY_W);

  `ST_ADAPTER_DEPTH_CHECK(DEPTH, IN_RL, OUT_RL)

  logic [PAY_W-1:0] wdata;
  logic [PAY_W-1:0] rdata;
  logic             push_req;
  logic             illegal_beat;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Reserve room for every beat that may still arrive on grants already issued.
  assign in_ready = (int'(occupancy) + IN_RL) < DEPTH;

  assign wdata = {in_data, in_startofpacket, in_endofpacket, in_empty};
  assign {out_data, out_startofpacket, out_endofpacket, out_empty} = rdata;

  if (IN_RL == 0) begin : g_in_rl0
    assign push_req     = in_valid && in_ready;
    assign illegal_beat = 1'b0;
  end else begin : g_in_rl
    logic [IN_RL-1:0] rdy_hist;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdy_hist <= '0;
      end else begin
        rdy_hist <= (rdy_hist << 1) | IN_RL'(in_ready);
      end
    end

    assign push_req     = in_valid;
    assign illegal_beat = in_valid && !rdy_hist[IN_RL-1];
  end

  if (OUT_RL == 0) begin : g_out_rl0
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
  end else begin : g_out_rl
    logic [OUT_RL-1:0] orh;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        orh <= '0;
      end else begin
        orh <= (orh << 1) | OUT_RL'(out_ready);
      end
    end

    // The sink granted this cycle OUT_RL cycles ago, so presenting a beat commits the pop.
    assign out_valid = !fifo_empty && orh[OUT_RL-1];
    assign fifo_pop  = out_valid;
  end

  st_sc_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (fifo_pop),
    .wdata   (wdata),
    .rdata   (rdata),
    .count   (occupancy),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (push_req && fifo_full) begin
        overflow_err <= 1'b1;
      end
      if (illegal_beat) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_st_latency_adapter.sv
// Directed bench for st_latency_adapter: four latency/depth configurations driven from
// one sequence, with a vector table for the basic flow and hand sequences for corners.
module tb_st_latency_adapter;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        out_ready;
  } drv_t;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [35:0] exp_payload;
    logic [2:0]  exp_occ;
  } vec_t;

  localparam logic [31:0] A1 = 32'hA000_0001;
  localparam logic [31:0] A2 = 32'hA000_0002;
  localparam logic [31:0] A3 = 32'hA000_0003;
  localparam logic [31:0] A4 = 32'hA000_0004;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  drv_t da = '0;
  drv_t db = '0;
  drv_t dc = '0;
  drv_t dd = '0;

  logic        a_in_ready, a_out_valid, a_sop, a_eop, a_ovf, a_perr;
  logic [31:0] a_out_data;
  logic [1:0]  a_empty;
  logic [2:0]  a_occ;
  logic        b_in_ready, b_out_valid, b_sop, b_eop, b_ovf, b_perr;
  logic [31:0] b_out_data;
  logic [1:0]  b_empty;
  logic [2:0]  b_occ;
  logic        c_in_ready, c_out_valid, c_sop, c_eop, c_ovf, c_perr;
  logic [31:0] c_out_data;
  logic [1:0]  c_empty;
  logic [2:0]  c_occ;
  logic        d_in_ready, d_out_valid, d_sop, d_eop, d_ovf, d_perr;
  logic [31:0] d_out_data;
  logic [1:0]  d_empty;
  logic [1:0]  d_occ;

  always #5 clk = ~clk;

  st_latency_adapter #(.DATA_W(32), .EMPTY_W(2), .IN_RL(1), .OUT_RL(0), .DEPTH(4)) u_a (
    .clk(clk), .reset_n(reset_n), .in_ready(a_in_ready), .in_valid(da.valid),
    .in_data(da.data), .in_startofpacket(da.sop), .in_endofpacket(da.eop), .in_empty(da.empty),
    .out_ready(da.out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_startofpacket(a_sop), .out_endofpacket(a_eop), .out_empty(a_empty),
    .occupancy(a_occ), .overflow_err(a_ovf), .protocol_err(a_perr));

  st_latency_adapter #(.DATA_W(32), .EMPTY_W(2), .IN_RL(4), .OUT_RL(0), .DEPTH(5)) u_b (
    .clk(clk), .reset_n(reset_n), .in_ready(b_in_ready), .in_valid(db.valid),
    .in_data(db.data), .in_startofpacket(db.sop), .in_endofpacket(db.eop), .in_empty(db.empty),
    .out_ready(db.out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_startofpacket(b_sop), .out_endofpacket(b_eop), .out_empty(b_empty),
    .occupancy(b_occ), .overflow_err(b_ovf), .protocol_err(b_perr));

  st_latency_adapter #(.DATA_W(32), .EMPTY_W(2), .IN_RL(0), .OUT_RL(2), .DEPTH(4)) u_c (
    .clk(clk), .reset_n(reset_n), .in_ready(c_in_ready), .in_valid(dc.valid),
    .in_data(dc.data), .in_startofpacket(dc.sop), .in_endofpacket(dc.eop), .in_empty(dc.empty),
    .out_ready(dc.out_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_startofpacket(c_sop), .out_endofpacket(c_eop), .out_empty(c_empty),
    .occupancy(c_occ), .overflow_err(c_ovf), .protocol_err(c_perr));

  st_latency_adapter #(.DATA_W(32), .EMPTY_W(2), .IN_RL(2), .OUT_RL(0), .DEPTH(3)) u_d (
    .clk(clk), .reset_n(reset_n), .in_ready(d_in_ready), .in_valid(dd.valid),
    .in_data(dd.data), .in_startofpacket(dd.sop), .in_endofpacket(dd.eop), .in_empty(dd.empty),
    .out_ready(dd.out_ready), .out_valid(d_out_valid), .out_data(d_out_data),
    .out_startofpacket(d_sop), .out_endofpacket(d_eop), .out_empty(d_empty),
    .occupancy(d_occ), .overflow_err(d_ovf), .protocol_err(d_perr));

  function automatic logic [35:0] pay(input logic [31:0] d, input logic s, input logic e,
                                      input logic [1:0] em);
    return {d, s, e, em};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic s, input logic e,
                              input logic [1:0] em, input logic ordy, input logic eir,
                              input logic eov, input logic [35:0] epay, input logic [2:0] eocc);
    vec_t r;
    r.valid = v;  r.data = d;  r.sop = s;  r.eop = e;  r.empty = em;  r.out_ready = ordy;
    r.exp_in_ready = eir;  r.exp_out_valid = eov;  r.exp_payload = epay;  r.exp_occ = eocc;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    nextCycle();
    da.valid = v.valid;  da.data = v.data;  da.sop = v.sop;  da.eop = v.eop;
    da.empty = v.empty;  da.out_ready = v.out_ready;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [11];
    logic [35:0] sb [$];
    logic [15:0] ordy_pat;
    logic [1:0]  up_hist;
    logic [35:0] beat;
    int          sent, recv, cyc;
    logic        exp_ov;

    vecs[0]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
    vecs[1]  = mk(1'b1, A1,    1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
    vecs[2]  = mk(1'b1, A2,    1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, pay(A1, 1'b1, 1'b0, 2'd0), 3'd1);
    vecs[3]  = mk(1'b1, A3,    1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, pay(A1, 1'b1, 1'b0, 2'd0), 3'd2);
    vecs[4]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pay(A1, 1'b1, 1'b0, 2'd0), 3'd3);
    vecs[5]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, pay(A1, 1'b1, 1'b0, 2'd0), 3'd3);
    vecs[6]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, pay(A2, 1'b0, 1'b0, 2'd0), 3'd2);
    vecs[7]  = mk(1'b1, A4,    1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, pay(A3, 1'b0, 1'b0, 2'd0), 3'd1);
    vecs[8]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, pay(A4, 1'b0, 1'b1, 2'd2), 3'd1);
    vecs[9]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, pay(A4, 1'b0, 1'b1, 2'd2), 3'd1);
    vecs[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, '0, 3'd0);

    // Reset values while reset_n is held low.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", a_in_ready, 1);
    checkOutput("rst_out_valid", a_out_valid, 0);
    checkOutput("rst_occ", a_occ, 0);
    checkOutput("rst_payload", pay(a_out_data, a_sop, a_eop, a_empty), 0);
    checkOutput("rst_ovf", a_ovf, 0);
    checkOutput("rst_perr", a_perr, 0);
    checkOutput("rst_c_out_valid", c_out_valid, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_in_ready", i), a_in_ready, vecs[i].exp_in_ready);
      checkOutput($sformatf("vec%0d_out_valid", i), a_out_valid, vecs[i].exp_out_valid);
      checkOutput($sformatf("vec%0d_occ", i), a_occ, vecs[i].exp_occ);
      if (vecs[i].exp_out_valid) begin
        checkOutput($sformatf("vec%0d_payload", i), pay(a_out_data, a_sop, a_eop, a_empty),
                    vecs[i].exp_payload);
      end
    end

    // Back-to-back beats 0..19 with the sink always ready: one-cycle latency, occupancy 1.
    for (int i = 0; i < 22; i++) begin
      nextCycle();
      da.valid = (i < 20);  da.data = 32'(i);  da.sop = (i == 0);  da.eop = (i == 19);
      da.empty = 2'd0;  da.out_ready = 1'b1;
      #1;
      exp_ov = (i >= 1 && i <= 20);
      checkOutput($sformatf("b2b%0d_out_valid", i), a_out_valid, exp_ov);
      checkOutput($sformatf("b2b%0d_occ", i), a_occ, exp_ov);
      if (exp_ov) begin
        checkOutput($sformatf("b2b%0d_payload", i), pay(a_out_data, a_sop, a_eop, a_empty),
                    pay(32'(i - 1), i == 1, i == 20, 2'd0));
      end
    end
    checkOutput("b2b_ovf", a_ovf, 0);
    checkOutput("b2b_perr", a_perr, 0);

    // IN_RL=4, DEPTH=5, sink stalled: grants issued before and at c0 yield exactly 5 beats.
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      db.valid = (c <= 4);  db.data = 32'hB000_0000 + 32'(c);
      #1;
      checkOutput($sformatf("rl4_c%0d_in_ready", c), b_in_ready, c == 0);
      checkOutput($sformatf("rl4_c%0d_occ", c), b_occ, (c < 5) ? c : 5);
      checkOutput($sformatf("rl4_c%0d_ovf", c), b_ovf, 0);
    end
    checkOutput("rl4_head", pay(b_out_data, b_sop, b_eop, b_empty), pay(32'hB000_0000, 1'b0, 1'b0, 2'd0));
    checkOutput("rl4_out_valid", b_out_valid, 1);
    checkOutput("rl4_perr", b_perr, 0);

    // OUT_RL=2: preload three beats, then toggle out_ready 1,0,1,0...
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      dc.valid = 1'b1;  dc.data = 32'hC000_0000 + 32'(k);  dc.out_ready = 1'b0;
      #1;
      checkOutput($sformatf("orl2_load%0d_out_valid", k), c_out_valid, 0);
      checkOutput($sformatf("orl2_load%0d_in_ready", k), c_in_ready, 1);
    end
    for (int k = 0; k < 9; k++) begin
      nextCycle();
      dc.valid = 1'b0;  dc.out_ready = (k % 2 == 0);
      #1;
      exp_ov = (k == 2 || k == 4 || k == 6);
      checkOutput($sformatf("orl2_k%0d_out_valid", k), c_out_valid, exp_ov);
      checkOutput($sformatf("orl2_k%0d_occ", k), c_occ, (k <= 2) ? 3 : (k <= 4) ? 2 : (k <= 6) ? 1 : 0);
      if (exp_ov) begin
        checkOutput($sformatf("orl2_k%0d_data", k), c_out_data, 32'hC000_0000 + 32'((k - 2) / 2));
      end
    end
    checkOutput("orl2_ovf", c_ovf, 0);
    checkOutput("orl2_perr", c_perr, 0);

    // DEPTH=3 wrap: upstream honours IN_RL=2 grants, sink follows a fixed irregular pattern.
    ordy_pat = 16'b1011_0010_1110_0101;
    up_hist  = 2'b11;
    sent = 0;  recv = 0;  cyc = 0;
    while (recv < 10 && cyc < 200) begin
      nextCycle();
      dd.valid = up_hist[1] && (sent < 10);
      dd.data  = 32'hD000_0000 + 32'(sent);
      dd.sop   = (sent % 5 == 0);
      dd.eop   = (sent % 5 == 4);
      dd.empty = 2'(sent);
      dd.out_ready = ordy_pat[cyc % 16];
      #1;
      checkOutput("wrap_occ", d_occ, sb.size());
      checkOutput("wrap_out_valid", d_out_valid, sb.size() != 0);
      checkOutput("wrap_in_ready", d_in_ready, sb.size() == 0);
      if (sb.size() != 0 && dd.out_ready) begin
        checkOutput($sformatf("wrap_beat%0d", recv), pay(d_out_data, d_sop, d_eop, d_empty), sb[0]);
        void'(sb.pop_front());
        recv++;
      end
      if (dd.valid) begin
        sb.push_back(pay(dd.data, dd.sop, dd.eop, dd.empty));
        sent++;
      end
      up_hist = {up_hist[0], d_in_ready};
      cyc++;
    end
    checkOutput("wrap_all_delivered", recv, 10);
    checkOutput("wrap_perr", d_perr, 0);

    // Protocol violation and overflow on the IN_RL=2, DEPTH=3 instance.
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      dd.valid = 1'b0;  dd.out_ready = 1'b0;
    end
    beat = pay(32'hE000_0000, 1'b1, 1'b0, 2'd0);
    nextCycle();
    dd.valid = 1'b1;  {dd.data, dd.sop, dd.eop, dd.empty} = beat;
    #1;
    checkOutput("err_p0_perr", d_perr, 0);
    checkOutput("err_p0_occ", d_occ, 0);
    nextCycle();
    dd.valid = 1'b0;
    #1;
    checkOutput("err_p1_occ", d_occ, 1);
    checkOutput("err_p1_in_ready", d_in_ready, 0);
    nextCycle();
    nextCycle();
    dd.valid = 1'b1;  dd.data = 32'hE000_0001;  dd.sop = 1'b0;
    #1;
    checkOutput("err_p3_perr", d_perr, 0);
    nextCycle();
    dd.data = 32'hE000_0002;
    #1;
    checkOutput("err_p4_perr", d_perr, 1);
    checkOutput("err_p4_occ", d_occ, 2);
    nextCycle();
    dd.data = 32'hE000_0003;
    #1;
    checkOutput("err_p5_occ", d_occ, 3);
    checkOutput("err_p5_ovf", d_ovf, 0);
    for (int i = 6; i < 8; i++) begin
      nextCycle();
      dd.valid = 1'b0;
      #1;
      checkOutput($sformatf("err_p%0d_ovf", i), d_ovf, 1);
      checkOutput($sformatf("err_p%0d_perr", i), d_perr, 1);
      checkOutput($sformatf("err_p%0d_occ", i), d_occ, 3);
      checkOutput($sformatf("err_p%0d_head", i), pay(d_out_data, d_sop, d_eop, d_empty), beat);
    end

    // Mid-packet asynchronous reset with three beats stored, then a clean packet.
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      da.valid = 1'b1;  da.data = 32'h1234_0000 + 32'(i);  da.sop = (i == 0);
      da.eop = 1'b0;  da.out_ready = 1'b0;
    end
    nextCycle();
    da.valid = 1'b0;
    #1;
    checkOutput("rst_mid_occ_before", a_occ, 3);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_occ", a_occ, 0);
    checkOutput("rst_mid_out_valid", a_out_valid, 0);
    checkOutput("rst_mid_in_ready", a_in_ready, 1);
    checkOutput("rst_mid_payload", pay(a_out_data, a_sop, a_eop, a_empty), 0);
    checkOutput("rst_mid_d_ovf", d_ovf, 0);
    checkOutput("rst_mid_d_perr", d_perr, 0);
    checkOutput("rst_mid_b_occ", b_occ, 0);
    nextCycle();
    reset_n = 1'b1;
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      da.valid = (i < 3);  da.data = 32'h5EED_0000 + 32'(i);  da.sop = (i == 0);
      da.eop = (i == 2);  da.empty = 2'd1;  da.out_ready = 1'b1;
      #1;
      checkOutput($sformatf("post_rst%0d_out_valid", i), a_out_valid, i >= 1);
      if (i >= 1) begin
        checkOutput($sformatf("post_rst%0d_payload", i), pay(a_out_data, a_sop, a_eop, a_empty),
                    pay(32'h5EED_0000 + 32'(i - 1), i == 1, i == 3, 2'd1));
      end
    end
    da.valid = 1'b0;
    nextCycle();
    checkOutput("post_rst_occ", a_occ, 0);
    checkOutput("post_rst_perr", a_perr, 0);
    checkOutput("post_rst_ovf", a_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
